sincos_seq: RTL and testbench

Sequencer and flow controller for the polynomial Sin/Cos datapath in the AWGN Box-Muller chain. It accepts a burst of 16-bit phase samples u1 over a valid/ready input, issues them to the free-running, non-stallable Sin/Cos pipeline, and tracks each sample through the fixed pipeline latency. It captures the resulting g0/g1 pairs into an output FIFO with valid/ready backpressure. Credit accounting guarantees the datapath never produces a result with nowhere to store it.

---
 rtl/sincos_pkg.sv | 25 ++
 rtl/sincos_seq_if.sv | 26 ++
 rtl/sincos_out_fifo.sv | 67 ++++++
 rtl/sincos_seq.sv | 128 ++++++++++++
 tb/tb_sincos_seq.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sincos_pkg.sv
// Shared definitions for the Sin/Cos sequencer slice.
//   LAT       : Sin/Cos datapath latency (sc_u1 change -> matching sc_g0/sc_g1)
//   SAMPLE_W  : width of phase samples and g outputs
//   sample_t  : one phase sample or one g value
//   state_t   : sequencer FSM states
//   g_pair_t  : one {g0, g1} result pair as stored in the output FIFO
package sincos_pkg;

  localparam int LAT      = 7;
  localparam int SAMPLE_W = 16;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  typedef struct packed {
    sample_t g0;
    sample_t g1;
  } g_pair_t;

endpackage

// File: rtl/sincos_seq_if.sv
// Streaming handshakes of the Sin/Cos sequencer.
//   in_valid/in_data/in_ready     : phase samples u1 into the sequencer
//   out_valid/out_g0/out_g1/out_ready : result pairs out of the FIFO head
// The slave modport is the sequencer's view; master is the producer/consumer.
interface sincos_seq_if;
  import sincos_pkg::*;

  logic    in_valid;
  sample_t in_data;
  logic    in_ready;
  logic    out_valid;
  sample_t out_g0;
  sample_t out_g1;
  logic    out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_g0, out_g1
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_g0, out_g1
  );

endinterface

// File: rtl/sincos_out_fifo.sv
// Synchronous FIFO for g-pairs, arbitrary depth, with occupancy output.
//   clk, rst_n : clock, asynchronous active-low reset (clears pointers/count)
//   push       : write push_data at the tail (caller guarantees not full,
//                or full together with pop)
//   push_data  : pair to write
//   pop        : remove the head (ignored when empty)
//   head       : current head pair, forced to zero while empty
//   valid      : FIFO not empty
//   count      : number of stored entries
module sincos_out_fifo
  import sincos_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  g_pair_t                      push_data,
  input  logic                         pop,
  output g_pair_t                      head,
  output logic                         valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  g_pair_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign valid  = (count != '0);
  assign pop_ok = pop && valid;
  // Masking the head keeps the output at zero after reset without
  // having to clear the storage array.
  assign head   = valid ? mem[rd_ptr] : '0;

  // NOTE: storage is deliberately not reset; only pointers and count are,
  // which keeps the array a plain RAM and is enough to make it logically empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sincos_seq.sv
// Sequencer / flow controller for the free-running Sin/Cos datapath.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : begin a burst (only looked at in IDLE)
//   num_samples : burst length, latched when start is taken
//   busy        : high in RUN and DRAIN
//   done        : one-cycle pulse at burst completion
//   io          : in_* sample stream and out_* result stream (slave side)
//   sc_u1       : registered phase to the datapath
//   sc_g0/sc_g1 : datapath outputs, valid LAT cycles after sc_u1 changes
// Each accepted sample is tracked through a LAT+1 stage valid shift
// register; a credit check against inflight + FIFO occupancy ensures the
// non-stallable datapath never returns a result the FIFO cannot hold.
module sincos_seq
  import sincos_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  output logic             busy,
  output logic             done,
  sincos_seq_if.slave      io,
  output sample_t          sc_u1,
  input  sample_t          sc_g0,
  input  sample_t          sc_g1
);

  localparam int INF_W  = $clog2(LAT+2);
  localparam int FCNT_W = $clog2(FIFO_DEPTH+1);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   remaining;
  logic [LAT:0]       vsr;
  logic [INF_W-1:0]   inflight;
  logic [FCNT_W-1:0]  fifo_count;
  logic               fifo_valid;
  logic               accept;
  logic               retire;
  logic               pop;
  logic               start_burst;
  logic               drain_empty;
  logic               done_set;
  g_pair_t            head;

  assign accept      = io.in_valid && io.in_ready;
  assign retire      = vsr[LAT];
  assign pop         = io.out_valid && io.out_ready;
  assign start_burst = (state == IDLE) && start && (num_samples != '0);
  assign drain_empty = (inflight == '0) && !fifo_valid;

  // Every accepted sample holds one credit until it leaves the FIFO.
  assign io.in_ready = (state == RUN) && (remaining != '0) &&
                       ((32'(inflight) + 32'(fifo_count)) < 32'(FIFO_DEPTH));

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_burst) state_nxt = RUN;
      RUN:     if (accept && (remaining == CNT_W'(1))) state_nxt = DRAIN;
      DRAIN:   if (drain_empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  // NOTE: every signal written here gets a default first so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    busy     = (state != IDLE);
    done_set = 1'b0;
    if ((state == IDLE) && start && (num_samples == '0)) done_set = 1'b1;
    if ((state == DRAIN) && drain_empty)                 done_set = 1'b1;
  end

  // Burst counter, phase register, valid tracking and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= '0;
      sc_u1     <= '0;
      vsr       <= '0;
      inflight  <= '0;
      done      <= 1'b0;
    end else begin
      done <= done_set;
      // Idle slots shift in a 0 so the matching datapath output is dropped.
      vsr  <= {vsr[LAT-1:0], accept};
      if (accept) sc_u1 <= io.in_data;

      if (start_burst)  remaining <= num_samples;
      else if (accept)  remaining <= remaining - CNT_W'(1);

      case ({accept, retire})
        2'b10:   inflight <= inflight + INF_W'(1);
        2'b01:   inflight <= inflight - INF_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  sincos_out_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (retire),
    .push_data ('{g0: sc_g0, g1: sc_g1}),
    .pop       (pop),
    .head      (head),
    .valid     (fifo_valid),
    .count     (fifo_count)
  );

  assign io.out_valid = fifo_valid;
  assign io.out_g0    = head.g0;
  assign io.out_g1    = head.g1;

endmodule

// File: tb/tb_sincos_seq.sv
// Self-checking bench for sincos_seq with a stub datapath
// (sc_g0 = sc_u1, sc_g1 = ~sc_u1, delayed LAT cycles).
module tb_sincos_seq;
  import sincos_pkg::*;

  localparam int DEPTH = 16;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] num_samples;
  logic          busy;
  logic          done;
  sample_t       sc_u1;
  sample_t       sc_g0;
  sample_t       sc_g1;

  sincos_seq_if sif ();

  sincos_seq #(
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_samples (num_samples),
    .busy        (busy),
    .done        (done),
    .io          (sif.slave),
    .sc_u1       (sc_u1),
    .sc_g0       (sc_g0),
    .sc_g1       (sc_g1)
  );

  always #5 clk = ~clk;

  // Stub datapath: pure LAT-cycle delay of sc_u1.
  sample_t dl [LAT];
  always @(posedge clk) begin
    dl[0] <= sc_u1;
    for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
  end
  assign sc_g0 = dl[LAT-1];
  assign sc_g1 = ~dl[LAT-1];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Transaction-level model: a queue of accepted samples, each becoming
  // visible LAT+2 cycles after its accept; credits = queue occupancy.
  // ---------------------------------------------------------------------
  typedef struct {
    sample_t u;
    int      avail;
  } exp_t;

  exp_t    exp_q [$];
  int      cyc = 0;
  bit      m_busy = 0;
  bit      m_done = 0;
  int      m_rem = 0;
  sample_t m_u1 = '0;

  // Observations for directed checks.
  int      acc_cnt = 0;
  int      pop_cnt = 0;
  int      done_cnt = 0;
  int      busy_cnt = 0;
  int      acc_cyc [$];
  int      pop_cyc [$];
  sample_t pop_g0 [$];
  sample_t pop_g1 [$];

  always @(negedge clk) begin : monitor
    bit      exp_ir;
    bit      exp_ov;
    bit      acc;
    bit      pp;
    bit      nd;
    sample_t inv;
    if (!rst_n) begin
      exp_q.delete();
      m_busy = 0;
      m_done = 0;
      m_rem  = 0;
      m_u1   = '0;
      check("rst_in_ready",  sif.in_ready,  0);
      check("rst_out_valid", sif.out_valid, 0);
      check("rst_busy",      busy,          0);
      check("rst_done",      done,          0);
      check("rst_sc_u1",     sc_u1,         0);
      check("rst_out_g0",    sif.out_g0,    0);
      check("rst_out_g1",    sif.out_g1,    0);
    end else begin
      exp_ir = m_busy && (m_rem > 0) && (exp_q.size() < DEPTH);
      exp_ov = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
      check("in_ready",  sif.in_ready,  exp_ir);
      check("out_valid", sif.out_valid, exp_ov);
      check("busy",      busy,          m_busy);
      check("done",      done,          m_done);
      check("sc_u1",     sc_u1,         m_u1);
      if (exp_ov && sif.out_valid) begin
        inv = ~exp_q[0].u;
        check("out_g0", sif.out_g0, exp_q[0].u);
        check("out_g1", sif.out_g1, inv);
      end
      if (dut.retire) check("push_while_full", dut.fifo_count == DEPTH, 0);

      if (sif.in_valid && sif.in_ready) begin
        acc_cnt++;
        acc_cyc.push_back(cyc);
      end
      if (sif.out_valid && sif.out_ready) begin
        pop_cnt++;
        pop_cyc.push_back(cyc);
        pop_g0.push_back(sif.out_g0);
        pop_g1.push_back(sif.out_g1);
      end
      if (done) done_cnt++;
      if (busy) busy_cnt++;

      // Advance the model across the coming edge.
      acc = sif.in_valid && exp_ir;
      pp  = exp_ov && sif.out_ready;
      nd  = 0;
      if (!m_busy) begin
        if (start) begin
          if (num_samples == '0) nd = 1;
          else begin
            m_busy = 1;
            m_rem  = int'(num_samples);
          end
        end
      end else if (m_rem == 0 && exp_q.size() == 0) begin
        m_busy = 0;
        nd     = 1;
      end
      if (pp) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back('{u: sif.in_data, avail: cyc + LAT + 2});
        m_rem--;
        m_u1 = sif.in_data;
      end
      m_done = nd;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feed samples d0 + step*idx until done is seen (bounded).
  task automatic stream(input sample_t d0, input sample_t step, input int idx0,
                        input int restart_at, input logic [CW-1:0] restart_num,
                        input int max_cyc);
    int b_acc  = acc_cnt;
    int b_done = done_cnt;
    int k      = 0;
    sif.in_valid = 1'b1;
    while (done_cnt == b_done && k < max_cyc) begin
      sif.in_data = d0 + step * sample_t'(idx0 + acc_cnt - b_acc);
      start = (k == restart_at);
      if (k == restart_at) num_samples = restart_num;
      tick();
      k++;
    end
    start        = 1'b0;
    sif.in_valid = 1'b0;
    check("stream_done_seen", done_cnt - b_done, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1);
  end

  initial begin : stim
    int      b_acc;
    int      b_pop;
    int      b_done;
    int      b_busy;
    int      k;
    sample_t e_g0 [4];
    sample_t e_g1 [4];
    sample_t ev;

    // 1: reset with start and in_valid high.
    rst_n         = 1'b0;
    start         = 1'b1;
    num_samples   = 16'd5;
    sif.in_valid  = 1'b1;
    sif.in_data   = 16'h1234;
    sif.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t1_in_ready",  sif.in_ready,  0);
    check("t1_out_valid", sif.out_valid, 0);
    check("t1_busy",      busy,          0);
    check("t1_sc_u1",     sc_u1,         0);
    start = 1'b0;
    rst_n = 1'b1;
    b_acc = acc_cnt;
    repeat (4) tick();
    check("t1_no_accept", acc_cnt - b_acc, 0);
    sif.in_valid = 1'b0;

    // 2: burst of 4 quadrant phases, back to back.
    e_g0 = '{16'h0000, 16'h4000, 16'h8000, 16'hC000};
    e_g1 = '{16'hFFFF, 16'hBFFF, 16'h7FFF, 16'h3FFF};
    b_acc = acc_cnt; b_pop = pop_cnt; b_done = done_cnt;
    start = 1'b1; num_samples = 16'd4;
    tick();
    start = 1'b0;
    stream(16'h0000, 16'h4000, 0, -1, '0, 60);
    repeat (3) tick();
    check("t2_accepts", acc_cnt - b_acc, 4);
    check("t2_pops",    pop_cnt - b_pop, 4);
    check("t2_done_once", done_cnt - b_done, 1);
    if (acc_cyc.size() >= b_acc + 4 && pop_cyc.size() > b_pop) begin
      check("t2_back_to_back", acc_cyc[b_acc+3] - acc_cyc[b_acc], 3);
      check("t2_latency", pop_cyc[b_pop] - acc_cyc[b_acc], LAT + 2);
    end
    for (int i = 0; i < 4; i++) begin
      if (pop_g0.size() > b_pop + i) begin
        check("t2_g0", pop_g0[b_pop+i], e_g0[i]);
        check("t2_g1", pop_g1[b_pop+i], e_g1[i]);
      end
    end

    // 3: 40 samples with the consumer stalled, then released.
    b_acc = acc_cnt; b_pop = pop_cnt;
    sif.out_ready = 1'b0;
    start = 1'b1; num_samples = 16'd40;
    tick();
    start = 1'b0;
    sif.in_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      sif.in_data = 16'h1000 + 16'h0101 * sample_t'(acc_cnt - b_acc);
      tick();
    end
    check("t3_credit_accepts", acc_cnt - b_acc, DEPTH);
    check("t3_in_ready_low",   sif.in_ready,    0);
    check("t3_no_pops",        pop_cnt - b_pop, 0);
    sif.out_ready = 1'b1;
    stream(16'h1000, 16'h0101, acc_cnt - b_acc, -1, '0, 400);
    check("t3_accepts", acc_cnt - b_acc, 40);
    check("t3_pops",    pop_cnt - b_pop, 40);
    for (int i = 0; i < 40; i++) begin
      if (pop_g0.size() > b_pop + i) begin
        ev = 16'h1000 + 16'h0101 * sample_t'(i);
        check("t3_order_g0", pop_g0[b_pop+i], ev);
      end
    end

    // 4: zero-length burst.
    b_acc = acc_cnt; b_done = done_cnt; b_busy = busy_cnt;
    start = 1'b1; num_samples = 16'd0;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("t4_done_once", done_cnt - b_done, 1);
    check("t4_no_busy",   busy_cnt - b_busy, 0);
    check("t4_no_accept", acc_cnt - b_acc,   0);

    // 5: start re-pulsed during RUN with a different count.
    b_acc = acc_cnt; b_pop = pop_cnt; b_done = done_cnt;
    start = 1'b1; num_samples = 16'd3;
    tick();
    start = 1'b0;
    stream(16'h2222, 16'h1111, 0, 1, 16'd9, 80);
    repeat (4) tick();
    check("t5_accepts",  acc_cnt - b_acc,   3);
    check("t5_pops",     pop_cnt - b_pop,   3);
    check("t5_done_once", done_cnt - b_done, 1);

    // 6: reset in the middle of a burst with samples in flight.
    b_acc = acc_cnt; b_done = done_cnt;
    sif.out_ready = 1'b0;
    start = 1'b1; num_samples = 16'd20;
    tick();
    start = 1'b0;
    sif.in_valid = 1'b1;
    k = 0;
    while (acc_cnt - b_acc < 8 && k < 30) begin
      sif.in_data = 16'h7000 + sample_t'(acc_cnt - b_acc);
      tick();
      k++;
    end
    sif.in_valid = 1'b0;
    k = 0;
    while (!sif.out_valid && k < 30) begin
      tick();
      k++;
    end
    check("t6_fifo_filled", sif.out_valid, 1);
    tick();
    tick();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t6_out_valid_async", sif.out_valid, 0);
    check("t6_busy_async",      busy,          0);
    check("t6_in_ready_async",  sif.in_ready,  0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check("t6_no_done", done_cnt - b_done, 0);
    sif.out_ready = 1'b1;
    b_pop = pop_cnt; b_acc = acc_cnt;
    start = 1'b1; num_samples = 16'd2;
    tick();
    start = 1'b0;
    stream(16'hA5A5, 16'hB5B5, 0, -1, '0, 60);
    repeat (6) tick();
    check("t6_accepts", acc_cnt - b_acc, 2);
    check("t6_pops",    pop_cnt - b_pop, 2);
    if (pop_g0.size() >= b_pop + 2) begin
      check("t6_g0_first",  pop_g0[b_pop],   16'hA5A5);
      check("t6_g1_first",  pop_g1[b_pop],   16'h5A5A);
      check("t6_g0_second", pop_g0[b_pop+1], 16'h5B5A);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
